// File: rtl/adc_chan_averager.sv
// Per-channel floor averager for an 8-channel serial ADC: issues periodic scan syncs,
// averages 2^AVG_LOG2 samples per channel and queues {channel, average} in a FWFT FIFO.
module adc_chan_averager #(
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_PERIOD = 1000,
  parameter int FIFO_LOG2   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        sync,
  input  logic        s_valid,
  input  logic [2:0]  s_channel,
  input  logic [11:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [2:0]  m_channel,
  output logic [11:0] m_data,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int AW    = 12 + AVG_LOG2;
  localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW    = $clog2(SYNC_PERIOD);
  localparam int PW    = FIFO_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [SW-1:0]        scnt_q, scnt_d;
  logic                 s_valid_d_q, s_valid_d_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [2:0]           s1_ch_q, s1_ch_d;
  logic [11:0]          s1_data_q, s1_data_d;
  logic [AW-1:0]        acc_q [8];
  logic [AW-1:0]        acc_d [8];
  logic [CW-1:0]        cnt_q [8];
  logic [CW-1:0]        cnt_d [8];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d;
  logic [14:0]          mem_q [DEPTH];

  logic                 sample_evt;
  logic [AW-1:0]        sum;
  logic                 last;
  logic                 push;
  logic [14:0]          push_entry;
  logic                 full, pop, wr_en, drop;
  logic [14:0]          head;

  assign sync = en && (scnt_q == SW'(SYNC_PERIOD - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    scnt_d = '0;
    if (en && (scnt_q != SW'(SYNC_PERIOD - 1))) scnt_d = scnt_q + SW'(1);

    s_valid_d_d = s_valid;
    sample_evt  = s_valid && !s_valid_d_q;
    s1_vld_d    = sample_evt;
    s1_ch_d     = sample_evt ? s_channel : s1_ch_q;
    s1_data_d   = sample_evt ? s_data    : s1_data_q;
  end

  // Stage 2: accumulate, or on the last sample of a block emit the floor average.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    sum        = acc_q[s1_ch_q] + AW'(s1_data_q);
    last       = (AVG_LOG2 == 0) || (cnt_q[s1_ch_q] == '1);
    push_entry = {s1_ch_q, 12'(sum >> AVG_LOG2)};
    if (s1_vld_q) begin
      if (last) begin
        push           = 1'b1;
        acc_d[s1_ch_q] = '0;
        cnt_d[s1_ch_q] = '0;
      end else begin
        acc_d[s1_ch_q] = sum;
        cnt_d[s1_ch_q] = cnt_q[s1_ch_q] + CW'(1);
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    m_valid  = (wr_ptr_q != rd_ptr_q);
    pop      = m_valid && m_ready;
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ovf_d    = (ovf_q && !clr_ovf) || drop;
    head     = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
  end

  assign m_channel = m_valid ? head[14:12] : 3'd0;
  assign m_data    = m_valid ? head[11:0]  : 12'd0;
  assign ovf       = ovf_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q      <= '0;
      s_valid_d_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      scnt_q      <= scnt_d;
      s_valid_d_q <= s_valid_d_d;
      s1_vld_q    <= s1_vld_d;
      s1_ch_q     <= s1_ch_d;
      s1_data_q   <= s1_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers define validity and the outputs are
  // masked to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_entry;
  end

endmodule

// File: tb/tb_adc_chan_averager.sv
// Directed plus randomized bench for adc_chan_averager against a sample-list reference model.
module tb_adc_chan_averager;

  localparam int NAVG  = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, en, sync, s_valid, m_valid, m_ready, ovf, clr_ovf;
  logic [2:0]  s_channel, m_channel;
  logic [11:0] s_data, m_data;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] d;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned samp_sum[8];
  int          samp_n[8];
  bit          exp_ovf;
  int          n_results;
  int          checks = 0;
  int          errors = 0;

  adc_chan_averager #(.AVG_LOG2(2), .SYNC_PERIOD(5), .FIFO_LOG2(3)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .s_valid(s_valid), .s_channel(s_channel), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_channel(m_channel), .m_data(m_data),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: collect samples per channel; every NAVG samples yields floor(mean).
  function automatic void model_sample(input int ch, input int data);
    ent_t e;
    samp_sum[ch] += data;
    samp_n[ch]++;
    if (samp_n[ch] == NAVG) begin
      e.ch = 3'(ch);
      e.d  = 12'(samp_sum[ch] / NAVG);
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else exp_ovf = 1'b1;
      n_results++;
      samp_sum[ch] = 0;
      samp_n[ch]   = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      samp_sum[i] = 0;
      samp_n[i]   = 0;
    end
  endfunction

  // One pulse: high for one cycle, low for one cycle; returns at the negedge after the capture edge.
  task automatic send(input int ch, input int data);
    @(negedge clk);
    s_valid   = 1'b1;
    s_channel = 3'(ch);
    s_data    = 12'(data);
    @(negedge clk);
    s_valid = 1'b0;
    model_sample(ch, data);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, m_valid, 1'b1);
      check({tag, "_ch"}, m_channel, exp_q[0].ch);
      check({tag, "_data"}, m_data, exp_q[0].d);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    check({tag, "_empty"}, m_valid, 1'b0);
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_channel = '0; s_data = '0;
    m_ready = 1'b0; clr_ovf = 1'b0; n_results = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_sync", sync, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_channel", m_channel, 3'd0);
    check("rst_m_data", m_data, 12'd0);
    check("rst_ovf", ovf, 1'b0);

    // Single block on ch3 with latency check.
    send(3, 100); send(3, 101); send(3, 102);
    send(3, 103);
    check("t1_lat_early", m_valid, 1'b0);
    @(negedge clk);
    check("t1_lat_valid", m_valid, 1'b1);
    check("t1_lat_data", m_data, 12'd101);
    drain("t1");

    // Round robin over all channels.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) send(c, 256 * c + c);
    repeat (2) @(negedge clk);
    check("t2_ovf", ovf, 1'b0);
    drain("t2");

    // Held s_valid level counts as one event.
    @(negedge clk);
    s_valid = 1'b1; s_channel = 3'd0; s_data = 12'd500;
    repeat (10) @(negedge clk);
    s_valid = 1'b0;
    model_sample(0, 500);
    for (int i = 0; i < 3; i++) send(0, 500);
    drain("t3");

    // Sync generator: pulses expected in cycles 4, 9 and 24.
    for (int cyc = 0; cyc < 28; cyc++) begin
      @(negedge clk);
      if (cyc == 0)  en = 1'b1;
      if (cyc == 12) en = 1'b0;
      if (cyc == 20) en = 1'b1;
      #1;
      check($sformatf("t5_sync_c%0d", cyc), sync, (cyc == 4 || cyc == 9 || cyc == 24));
    end
    @(negedge clk);
    en = 1'b0;

    // Randomized overflow: nine results with the sink stalled.
    n_results = 0;
    for (int i = 0; i < 400 && n_results < 9; i++)
      send($urandom_range(7), $urandom_range(4095));
    check("t4_results", n_results, 9);
    repeat (2) @(negedge clk);
    check("t4_ovf_set", ovf, exp_ovf);
    drain("t4");
    check("t4_ovf_sticky", ovf, 1'b1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check("t4_ovf_clr", ovf, 1'b0);

    // Reset discards partial accumulation.
    send(1, 1000); send(1, 1000);
    do_reset();
    check("t6_rst_valid", m_valid, 1'b0);
    for (int i = 0; i < 4; i++) send(1, 40);
    drain("t6");

    // Boundaries: full-scale without overflow, and floor rounding.
    for (int i = 0; i < 4; i++) send(7, 4095);
    send(2, 0); send(2, 0); send(2, 0); send(2, 3);
    drain("t7");

    // Randomized interleaving with stalled sink, then drain.
    for (int i = 0; i < 40; i++) send($urandom_range(7), $urandom_range(4095));
    repeat (2) @(negedge clk);
    check("t8_ovf", ovf, exp_ovf);
    drain("t8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
